// File: rtl/zz_rle_encoder.sv
// zz_rle_encoder: zigzag block to JPEG DC/AC/ZRL/EOB symbol stream.
// Ports: clk, rst (async high), blk_* block input handshake, sym_* symbol output handshake.
module zz_rle_encoder #(
    parameter int COEF_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  blk_valid,
    output logic                  blk_ready,
    input  logic [64*COEF_W-1:0]  blk_data,
    output logic                  sym_valid,
    input  logic                  sym_ready,
    output logic                  sym_dc,
    output logic [3:0]            sym_run,
    output logic [3:0]            sym_size,
    output logic [COEF_W:0]       sym_amp,
    output logic                  sym_last
);

    localparam int AW = COEF_W + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_DC, S_SCAN, S_ZRL, S_AC, S_EOB
    } state_t;

    state_t               r_state;
    logic [64*COEF_W-1:0] r_blk;
    logic [5:0]           r_idx;
    logic [5:0]           r_run;
    logic signed [COEF_W-1:0] r_prev_dc;

    logic          r_sym_valid;
    logic          r_sym_dc;
    logic [3:0]    r_sym_run;
    logic [3:0]    r_sym_size;
    logic [AW-1:0] r_sym_amp;
    logic          r_sym_last;

    logic signed [COEF_W-1:0] w_coef [64];
    logic signed [COEF_W-1:0] w_dc_in;
    logic signed [COEF_W-1:0] w_cur;
    logic signed [AW-1:0]     w_dc_diff;
    logic signed [AW-1:0]     w_cur_x;
    logic [3:0]               w_dc_cat;
    logic [3:0]               w_cur_cat;
    logic [AW-1:0]            w_dc_amp;
    logic [AW-1:0]            w_cur_amp;
    logic [5:0]               w_run_less;

    // Magnitude category: position of the highest set bit of |v|.
    function automatic logic [3:0] f_cat(input logic signed [AW-1:0] v);
        logic [AW-1:0] mag;
        logic [3:0]    c;
        mag = v[AW-1] ? -v : v;
        c   = 4'd0;
        for (int i = 0; i < AW; i++) begin
            if (mag[i]) c = 4'(i + 1);
        end
        return c;
    endfunction

    // Negative values are sent as (v-1) keeping only the low cat bits.
    function automatic logic [AW-1:0] f_enc(input logic signed [AW-1:0] v,
                                            input logic [3:0] c);
        logic [AW-1:0] mask;
        logic [AW-1:0] u;
        mask = ~({AW{1'b1}} << c);
        u    = v;
        return v[AW-1] ? ((u - AW'(1)) & mask) : u;
    endfunction

    for (genvar k = 0; k < 64; k++) begin : g_coef
        assign w_coef[k] = r_blk[(64-k)*COEF_W-1 -: COEF_W];
    end

    assign w_dc_in    = blk_data[64*COEF_W-1 -: COEF_W];
    assign w_dc_diff  = AW'(w_dc_in) - AW'(r_prev_dc);
    assign w_cur      = w_coef[r_idx];
    assign w_cur_x    = AW'(w_cur);
    assign w_dc_cat   = f_cat(w_dc_diff);
    assign w_cur_cat  = f_cat(w_cur_x);
    assign w_dc_amp   = f_enc(w_dc_diff, w_dc_cat);
    assign w_cur_amp  = f_enc(w_cur_x, w_cur_cat);
    assign w_run_less = r_run - 6'd16;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_blk       <= '0;
            r_idx       <= '0;
            r_run       <= '0;
            r_prev_dc   <= '0;
            r_sym_valid <= 1'b0;
            r_sym_dc    <= 1'b0;
            r_sym_run   <= '0;
            r_sym_size  <= '0;
            r_sym_amp   <= '0;
            r_sym_last  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (blk_valid) begin
                        r_blk       <= blk_data;
                        r_idx       <= 6'd1;
                        r_run       <= '0;
                        r_state     <= S_DC;
                        r_sym_valid <= 1'b1;
                        r_sym_dc    <= 1'b1;
                        r_sym_run   <= '0;
                        r_sym_size  <= w_dc_cat;
                        r_sym_amp   <= w_dc_amp;
                        r_sym_last  <= 1'b0;
                    end
                end
                S_DC: begin
                    if (sym_ready) begin
                        r_prev_dc   <= w_coef[0];
                        r_state     <= S_SCAN;
                        r_sym_valid <= 1'b0;
                        r_sym_dc    <= 1'b0;
                        r_sym_size  <= '0;
                        r_sym_amp   <= '0;
                    end
                end
                S_SCAN: begin
                    if (w_cur == '0) begin
                        if (r_idx == 6'd63) begin
                            // Trailing zeros collapse into EOB, no ZRL.
                            r_state     <= S_EOB;
                            r_sym_valid <= 1'b1;
                            r_sym_run   <= '0;
                            r_sym_size  <= '0;
                            r_sym_amp   <= '0;
                            r_sym_last  <= 1'b1;
                        end else begin
                            r_run <= r_run + 6'd1;
                            r_idx <= r_idx + 6'd1;
                        end
                    end else if (r_run >= 6'd16) begin
                        r_state     <= S_ZRL;
                        r_sym_valid <= 1'b1;
                        r_sym_run   <= 4'd15;
                        r_sym_size  <= '0;
                        r_sym_amp   <= '0;
                        r_sym_last  <= 1'b0;
                    end else begin
                        r_state     <= S_AC;
                        r_sym_valid <= 1'b1;
                        r_sym_run   <= r_run[3:0];
                        r_sym_size  <= w_cur_cat;
                        r_sym_amp   <= w_cur_amp;
                        r_sym_last  <= (r_idx == 6'd63);
                    end
                end
                S_ZRL: begin
                    if (sym_ready) begin
                        r_run <= w_run_less;
                        if (w_run_less < 6'd16) begin
                            r_state    <= S_AC;
                            r_sym_run  <= w_run_less[3:0];
                            r_sym_size <= w_cur_cat;
                            r_sym_amp  <= w_cur_amp;
                            r_sym_last <= (r_idx == 6'd63);
                        end
                    end
                end
                S_AC: begin
                    if (sym_ready) begin
                        r_run       <= '0;
                        r_sym_valid <= 1'b0;
                        r_sym_run   <= '0;
                        r_sym_size  <= '0;
                        r_sym_amp   <= '0;
                        r_sym_last  <= 1'b0;
                        if (r_idx == 6'd63) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_idx   <= r_idx + 6'd1;
                            r_state <= S_SCAN;
                        end
                    end
                end
                S_EOB: begin
                    if (sym_ready) begin
                        r_state     <= S_IDLE;
                        r_sym_valid <= 1'b0;
                        r_sym_last  <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign blk_ready = (r_state == S_IDLE);
    assign sym_valid = r_sym_valid;
    assign sym_dc    = r_sym_dc;
    assign sym_run   = r_sym_run;
    assign sym_size  = r_sym_size;
    assign sym_amp   = r_sym_amp;
    assign sym_last  = r_sym_last;

endmodule

// File: tb/tb_zz_rle_encoder.sv
// tb_zz_rle_encoder: scoreboard bench for zz_rle_encoder.
// Directed blocks push expected symbols; a monitor pops on each handshake.
module tb_zz_rle_encoder;

    localparam int W = 8;

    typedef struct packed {
        logic       dc;
        logic [3:0] run;
        logic [3:0] size;
        logic [8:0] amp;
        logic       last;
    } sym_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           blk_valid;
    logic           blk_ready;
    logic [64*W-1:0] blk_data;
    logic           sym_valid;
    logic           sym_ready;
    logic           sym_dc;
    logic [3:0]     sym_run;
    logic [3:0]     sym_size;
    logic [W:0]     sym_amp;
    logic           sym_last;

    sym_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   bp_en  = 0;
    logic [64*W-1:0] blk;
    logic prev_stall;
    sym_t prev_f;

    always #5 clk = ~clk;

    zz_rle_encoder #(.COEF_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .sym_valid (sym_valid),
        .sym_ready (sym_ready),
        .sym_dc    (sym_dc),
        .sym_run   (sym_run),
        .sym_size  (sym_size),
        .sym_amp   (sym_amp),
        .sym_last  (sym_last)
    );

    function automatic sym_t mk(input logic dc, input int run, input int size,
                                input int amp, input logic last);
        sym_t s;
        s.dc   = dc;
        s.run  = 4'(run);
        s.size = 4'(size);
        s.amp  = 9'(amp);
        s.last = last;
        return s;
    endfunction

    function automatic sym_t cur_sym();
        sym_t s;
        s = {sym_dc, sym_run, sym_size, sym_amp, sym_last};
        return s;
    endfunction

    task automatic chk(input bit ok, input string nm,
                       input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
        end
    endtask

    task automatic set_coef(input int k, input logic [W-1:0] v);
        blk[(64-k)*W-1 -: W] = v;
    endtask

    task automatic send_block(input logic [64*W-1:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!blk_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!blk_ready) begin
            chk(1'b0, "blk_ready_timeout", 32'(blk_ready), 32'd1);
            return;
        end
        blk_data  = d;
        blk_valid = 1'b1;
        @(posedge clk);
        #1 blk_valid = 1'b0;
    endtask

    task automatic wait_empty(input int limit);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk(exp_q.size() == 0, "drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        blk_valid  = 1'b0;
        blk_data   = '0;
        sym_ready  = 1'b1;
        prev_stall = 1'b0;
        prev_f     = '0;
        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        prev_stall = 1'b0;
                    end else begin
                        if (prev_stall) begin
                            chk(sym_valid && cur_sym() === prev_f, "stall_stable",
                                32'(cur_sym()), 32'(prev_f));
                        end
                        if (sym_valid && sym_ready) begin
                            if (exp_q.size() == 0) begin
                                chk(1'b0, "unexpected_symbol", 32'(cur_sym()), 32'd0);
                            end else begin
                                sym_t e;
                                e = exp_q.pop_front();
                                chk(cur_sym() === e, "symbol", 32'(cur_sym()), 32'(e));
                            end
                        end
                        prev_stall = sym_valid && !sym_ready;
                        prev_f     = cur_sym();
                    end
                end
            end
            begin : ready_drv
                int stall_cnt;
                stall_cnt = 0;
                forever begin
                    @(posedge clk);
                    #2;
                    if (!bp_en) begin
                        sym_ready = 1'b1;
                        stall_cnt = 0;
                    end else if (sym_valid) begin
                        if (stall_cnt < 5) begin
                            sym_ready = 1'b0;
                            stall_cnt++;
                        end else begin
                            sym_ready = 1'b1;
                            stall_cnt = 0;
                        end
                    end else begin
                        sym_ready = 1'b0;
                        stall_cnt = 0;
                    end
                end
            end
            begin : stim
                repeat (2) @(negedge clk);
                chk(blk_ready === 1'b1, "rst_blk_ready", 32'(blk_ready), 32'd1);
                chk(sym_valid === 1'b0, "rst_sym_valid", 32'(sym_valid), 32'd0);
                chk(cur_sym() === sym_t'(0), "rst_sym_fields", 32'(cur_sym()), 32'd0);
                @(posedge clk);
                #1 rst = 1'b0;

                // Block 1: DC=5, all AC zero; latency checks.
                blk = '0;
                set_coef(0, 8'sd5);
                exp_q.push_back(mk(1, 0, 3, 5, 0));
                exp_q.push_back(mk(0, 0, 0, 0, 1));
                send_block(blk);
                for (int n = 1; n <= 66; n++) begin
                    @(negedge clk);
                    if (n == 1)
                        chk(sym_valid && sym_dc, "lat_dc_c1", 32'({sym_valid, sym_dc}), 32'h3);
                    if (n == 64)
                        chk(sym_valid === 1'b0, "lat_idle_c64", 32'(sym_valid), 32'd0);
                    if (n == 65)
                        chk(sym_valid && sym_last, "lat_eob_c65",
                            32'({sym_valid, sym_last}), 32'h3);
                    if (n == 65)
                        chk(blk_ready === 1'b0, "lat_busy_c65", 32'(blk_ready), 32'd0);
                    if (n == 66)
                        chk(blk_ready === 1'b1, "lat_ready_c66", 32'(blk_ready), 32'd1);
                end
                wait_empty(10);

                // Block 2: DC=2 (diff -3), coef1=-1.
                blk = '0;
                set_coef(0, 8'sd2);
                set_coef(1, -8'sd1);
                exp_q.push_back(mk(1, 0, 2, 0, 0));
                exp_q.push_back(mk(0, 0, 1, 0, 0));
                exp_q.push_back(mk(0, 0, 0, 0, 1));
                send_block(blk);
                wait_empty(200);

                // Block 3: DC equal to previous (diff 0), coef20=127.
                blk = '0;
                set_coef(0, 8'sd2);
                set_coef(20, 8'sd127);
                exp_q.push_back(mk(1, 0, 0, 0, 0));
                exp_q.push_back(mk(0, 15, 0, 0, 0));
                exp_q.push_back(mk(0, 3, 7, 127, 0));
                exp_q.push_back(mk(0, 0, 0, 0, 1));
                send_block(blk);
                wait_empty(200);

                // Block 4: only coef63=-128; DC diff 0-2=-2.
                blk = '0;
                set_coef(63, 8'h80);
                exp_q.push_back(mk(1, 0, 2, 1, 0));
                exp_q.push_back(mk(0, 15, 0, 0, 0));
                exp_q.push_back(mk(0, 15, 0, 0, 0));
                exp_q.push_back(mk(0, 15, 0, 0, 0));
                exp_q.push_back(mk(0, 14, 8, 9'h07F, 1));
                send_block(blk);
                wait_empty(200);

                // Block 5: same data under back-pressure; DC diff 0.
                bp_en = 1;
                exp_q.push_back(mk(1, 0, 0, 0, 0));
                exp_q.push_back(mk(0, 15, 0, 0, 0));
                exp_q.push_back(mk(0, 15, 0, 0, 0));
                exp_q.push_back(mk(0, 15, 0, 0, 0));
                exp_q.push_back(mk(0, 14, 8, 9'h07F, 1));
                send_block(blk);
                wait_empty(400);
                bp_en = 0;
                repeat (2) @(negedge clk);

                // Block 6: DC=10, reset during SCAN discards the rest.
                blk = '0;
                set_coef(0, 8'sd10);
                set_coef(40, 8'sd3);
                exp_q.push_back(mk(1, 0, 4, 10, 0));
                send_block(blk);
                wait_empty(20);
                repeat (5) @(negedge clk);
                rst = 1'b1;
                #1;
                chk(sym_valid === 1'b0, "midrst_sym_valid", 32'(sym_valid), 32'd0);
                chk(blk_ready === 1'b1, "midrst_blk_ready", 32'(blk_ready), 32'd1);
                @(posedge clk);
                #1 rst = 1'b0;

                // Block 7: prev_dc cleared, so DC=10 again gives diff 10.
                blk = '0;
                set_coef(0, 8'sd10);
                exp_q.push_back(mk(1, 0, 4, 10, 0));
                exp_q.push_back(mk(0, 0, 0, 0, 1));
                send_block(blk);
                wait_empty(200);

                repeat (3) @(negedge clk);
                chk(sym_valid === 1'b0, "end_idle_valid", 32'(sym_valid), 32'd0);
                chk(blk_ready === 1'b1, "end_idle_ready", 32'(blk_ready), 32'd1);
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        join
    end

endmodule

// File: doc/zz_rle_encoder.md
Name: zz_rle_encoder

Overview:
- Entropy-prep stage directly downstream of the zigzag reorder block.
- Accepts one 8x8 block of quantized coefficients in zigzag order (64 bytes, element 0 in MSBs).
- Emits a serial stream of JPEG symbols: one DPCM-coded DC symbol, then AC (run,size,amplitude) symbols, ZRL and EOB.
- Output feeds the Huffman coder through a valid/ready handshake.

Parameters:
- COEF_W, 8, signed coefficient width. Legal range 2..10. blk_data is 64*COEF_W bits; sym_amp is COEF_W+1 bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- blk_valid  in  1  blk_data holds a full block.
- blk_ready  out  1  block accepted when blk_valid && blk_ready.
- blk_data  in  64*COEF_W  signed coefficients, zigzag index k at bits [(64-k)*COEF_W-1 -: COEF_W].
- sym_valid  out  1  symbol present.
- sym_ready  in  1  downstream accepts symbol when sym_valid && sym_ready.
- sym_dc  out  1  current symbol is the DC symbol.
- sym_run  out  4  zero run (AC); 0 for DC and EOB; 15 for ZRL.
- sym_size  out  4  magnitude category (bit count of |value|); 0 for ZRL/EOB.
- sym_amp  out  COEF_W+1  amplitude bits, right-aligned, upper bits zero.
- sym_last  out  1  final symbol of the block.

Behaviour:
- Reset (async, immediate):
  - state=IDLE; prev_dc=0.
  - blk_ready=1; sym_valid=0; sym_dc, sym_run, sym_size, sym_amp, sym_last all 0.
- States: IDLE, DC, SCAN, ZRL, AC, EOB. blk_ready=1 only in IDLE.
- IDLE:
  - On handshake, capture blk_data into an internal register; idx=1, run=0; next=DC.
- DC:
  - diff = coef[0] - prev_dc, computed at COEF_W+1 bits.
  - Present sym_dc=1, run=0, size=cat(diff), amp=enc(diff).
  - On acceptance: prev_dc <= coef[0]; next=SCAN.
- SCAN (sym_valid=0, one coefficient per cycle):
  - coef[idx]==0 and idx<63: run++, idx++.
  - coef[idx]==0 and idx==63: next=EOB.
  - coef[idx]!=0: next=ZRL if run>=16, else AC.
- ZRL:
  - Present run=15, size=0, amp=0.
  - On acceptance: run -= 16; next=ZRL if run still >=16, else AC.
- AC:
  - Present run, cat(coef[idx]), enc(coef[idx]); sym_last=(idx==63).
  - On acceptance: run=0.
  - If idx==63, next=IDLE; else idx++, next=SCAN.
- EOB:
  - Present run=0, size=0, amp=0, sym_last=1.
  - On acceptance: next=IDLE.
  - Trailing zeros never produce ZRL symbols.
- cat(v): 0 if v==0; otherwise floor(log2|v|)+1.
- enc(v): v if v>0; (v-1) truncated to cat(v) bits if v<0.
- Symbol outputs are registered. While sym_valid && !sym_ready, every sym_* field holds stable.
- sym_valid never drops without acceptance, except on rst.
- Latency, with sym_ready tied high:
  - Block accepted at cycle 0 → DC symbol valid at cycle 1.
  - Each zero coefficient costs 1 SCAN cycle; each nonzero costs 1 SCAN cycle plus 1 per symbol emitted.
  - All-zero block: EOB at cycle 65, blk_ready high again at cycle 66.
- prev_dc persists across blocks; it is cleared only by rst.
- rst mid-block: the in-flight block is discarded with no further symbols, and prev_dc=0.
- The AC run counter is 6 bits internally; sym_run is always <=15 when presented.

Test Plan:
- Reset then block with coef[0]=5, rest 0, sym_ready=1:
  - Cycle 1: DC (dc=1, size=3, amp=5).
  - Cycle 65: EOB (last=1).
  - Cycle 66: blk_ready=1.
- Second block with coef[0]=2 after the first:
  - DC diff=-3 → size=2, amp=0.
  - coef[1]=-1 → AC run=0, size=1, amp=0.
  - Then EOB.
- Block with coef[20]=127, others 0 (19 zeros before it):
  - DC size 0.
  - ZRL (15,0,0).
  - AC run=3, size=7, amp=127.
  - EOB, last=1.
- Block with only coef[63]=-128 (COEF_W=8):
  - Three ZRLs.
  - AC run=14, size=8, amp=0x7F, last=1.
  - No EOB.
- Back-pressure: hold sym_ready=0 for 5 cycles on each symbol of the previous case → every symbol field stays stable while stalled; the symbol sequence is unchanged.
- Assert rst during SCAN of a block with DC=10:
  - sym_valid=0 and blk_ready=1 immediately.
  - The next block with DC=10 emits diff size=4, amp=10.
